// File: rtl/mes_bcd_ctrl.sv
// Month register for the RTC date path: BCD month + binary index, user edit, write handshake.
// Optional write-abandon timeout enabled by defining MES_WR_TIMEOUT_EN.
module mes_bcd_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] rtc_data_in,
  input  logic       edit_en,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       wr_ack,
  output logic [7:0] mes_bcd,
  output logic [3:0] mes_idx,
  output logic       wr_req,
  output logic [7:0] wr_data,
  output logic       bcd_err,
  output logic       wr_timeout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EDIT  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] mes_bcd_q, mes_bcd_d;
  logic [3:0] mes_idx_q, mes_idx_d;
  logic       wr_req_q, wr_req_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       bcd_err_q, bcd_err_d;
  logic       dirty_q, dirty_d;
  logic [3:0] idx_up, idx_dn;

  function automatic logic bcd_valid(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    if (b[7:4] == 4'h0 && b[3:0] >= 4'h1 && b[3:0] <= 4'h9) ok = 1'b1;
    if (b[7:4] == 4'h1 && b[3:0] <= 4'h2) ok = 1'b1;
    return ok;
  endfunction

  // Caller guarantees a valid month; index = month - 1.
  function automatic logic [3:0] bcd_to_idx(input logic [7:0] b);
    logic [3:0] r;
    if (b[7:4] == 4'h1) r = 4'(b[3:0] + 4'd9);
    else                r = 4'(b[3:0] - 4'd1);
    return r;
  endfunction

  function automatic logic [7:0] idx_to_bcd(input logic [3:0] i);
    logic [7:0] r;
    if (i < 4'd9) r = {4'h0, 4'(i + 4'd1)};
    else          r = {4'h1, 4'(i - 4'd9)};
    return r;
  endfunction

  assign idx_up = (mes_idx_q >= 4'd11) ? 4'd0  : 4'(mes_idx_q + 4'd1);
  assign idx_dn = (mes_idx_q == 4'd0)  ? 4'd11 : 4'(mes_idx_q - 4'd1);

`ifdef MES_WR_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       wr_timeout_q, wr_timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    mes_bcd_d = mes_bcd_q;
    mes_idx_d = mes_idx_q;
    wr_req_d  = wr_req_q;
    wr_data_d = wr_data_q;
    bcd_err_d = bcd_err_q;
    dirty_d   = dirty_q;
`ifdef MES_WR_TIMEOUT_EN
    cnt_d        = cnt_q;
    wr_timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // A load in the same cycle as edit_en wins; EDIT follows next cycle.
        if (load) begin
          if (bcd_valid(rtc_data_in)) begin
            mes_bcd_d = rtc_data_in;
            mes_idx_d = bcd_to_idx(rtc_data_in);
            bcd_err_d = 1'b0;
          end else begin
            bcd_err_d = 1'b1;
          end
        end else if (edit_en) begin
          state_d = ST_EDIT;
          dirty_d = 1'b0;
        end
      end
      ST_EDIT: begin
        if (!edit_en) begin
          if (dirty_q) begin
            state_d   = ST_WRITE;
            wr_req_d  = 1'b1;
            wr_data_d = mes_bcd_q;
`ifdef MES_WR_TIMEOUT_EN
            cnt_d     = '0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end else if (btn_up && !btn_down) begin
          mes_idx_d = idx_up;
          mes_bcd_d = idx_to_bcd(idx_up);
          dirty_d   = 1'b1;
        end else if (btn_down && !btn_up) begin
          mes_idx_d = idx_dn;
          mes_bcd_d = idx_to_bcd(idx_dn);
          dirty_d   = 1'b1;
        end
      end
      ST_WRITE: begin
        if (wr_ack) begin
          state_d  = ST_IDLE;
          wr_req_d = 1'b0;
`ifdef MES_WR_TIMEOUT_EN
        end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          state_d      = ST_IDLE;
          wr_req_d     = 1'b0;
          wr_timeout_d = 1'b1;
        end else begin
          cnt_d = 8'(cnt_q + 8'd1);
`endif
        end
      end
      default: begin
        state_d  = ST_IDLE;
        wr_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mes_bcd_q <= 8'h01;
      mes_idx_q <= '0;
      wr_req_q  <= 1'b0;
      wr_data_q <= 8'h01;
      bcd_err_q <= 1'b0;
      dirty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mes_bcd_q <= mes_bcd_d;
      mes_idx_q <= mes_idx_d;
      wr_req_q  <= wr_req_d;
      wr_data_q <= wr_data_d;
      bcd_err_q <= bcd_err_d;
      dirty_q   <= dirty_d;
    end
  end

`ifdef MES_WR_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      wr_timeout_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      wr_timeout_q <= wr_timeout_d;
    end
  end
  assign wr_timeout = wr_timeout_q;
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(TIMEOUT_CYC);
  assign wr_timeout = 1'b0;
`endif

  assign mes_bcd = mes_bcd_q;
  assign mes_idx = mes_idx_q;
  assign wr_req  = wr_req_q;
  assign wr_data = wr_data_q;
  assign bcd_err = bcd_err_q;

endmodule

// File: tb/tb_mes_bcd_ctrl.sv
// Self-checking bench for mes_bcd_ctrl against an integer-month reference model.
module tb_mes_bcd_ctrl;

  localparam int TCYC = 4;
`ifdef MES_WR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [7:0] rtc_data_in = 8'h00;
  logic       edit_en = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       wr_ack = 1'b0;
  logic [7:0] mes_bcd;
  logic [3:0] mes_idx;
  logic       wr_req;
  logic [7:0] wr_data;
  logic       bcd_err;
  logic       wr_timeout;

  int vecs = 0;
  int fails = 0;

  mes_bcd_ctrl #(.TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .rtc_data_in(rtc_data_in),
    .edit_en(edit_en), .btn_up(btn_up), .btn_down(btn_down), .wr_ack(wr_ack),
    .mes_bcd(mes_bcd), .mes_idx(mes_idx), .wr_req(wr_req), .wr_data(wr_data),
    .bcd_err(bcd_err), .wr_timeout(wr_timeout)
  );

  always #5 clk = ~clk;

  logic [22:0] dut_vec;
  assign dut_vec = {mes_bcd, mes_idx, wr_req, wr_data, bcd_err, wr_timeout};

  // Reference model: month as integer 1..12, mode flags per the three operating modes.
  int   m_month;
  bit   m_err, m_editing, m_writing, m_dirty, m_req, m_tout;
  logic [7:0] m_wdata;
  int   m_wcyc;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    int hi, lo, v;
    hi = int'(b[7:4]);
    lo = int'(b[3:0]);
    if (hi > 9 || lo > 9) return 0;
    v = hi * 10 + lo;
    if (v < 1 || v > 12) return 0;
    return v;
  endfunction

  function automatic logic [22:0] exp_vec();
    return {to_bcd(m_month), 4'(m_month - 1), m_req, m_wdata, m_err, m_tout};
  endfunction

  task automatic model_reset();
    m_month = 1; m_err = 0; m_editing = 0; m_writing = 0; m_dirty = 0;
    m_req = 0; m_tout = 0; m_wdata = 8'h01; m_wcyc = 0;
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle.
  task automatic cyc(input bit ld, input logic [7:0] d, input bit en,
                     input bit up, input bit dn, input bit ack);
    int v;
    load = ld; rtc_data_in = d; edit_en = en; btn_up = up; btn_down = dn; wr_ack = ack;
    @(posedge clk);
    m_tout = 0;
    if (m_writing) begin
      if (ack) begin
        m_writing = 0; m_req = 0;
      end else begin
        m_wcyc++;
        if (TO_EN && m_wcyc == TCYC) begin
          m_writing = 0; m_req = 0; m_tout = 1;
        end
      end
    end else if (m_editing) begin
      if (!en) begin
        m_editing = 0;
        if (m_dirty) begin
          m_writing = 1; m_req = 1; m_wdata = to_bcd(m_month); m_wcyc = 0;
        end
      end else if (up && !dn) begin
        m_month = (m_month == 12) ? 1 : m_month + 1; m_dirty = 1;
      end else if (dn && !up) begin
        m_month = (m_month == 1) ? 12 : m_month - 1; m_dirty = 1;
      end
    end else begin
      if (ld) begin
        v = from_bcd(d);
        if (v != 0) begin m_month = v; m_err = 0; end
        else m_err = 1;
      end else if (en) begin
        m_editing = 1; m_dirty = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (dut_vec !== exp_vec()) begin
      fails++; $display("FAIL reset_held: got %h exp %h", dut_vec, exp_vec());
    end
    rst_n = 1;
    cyc(0, 8'h00, 0, 0, 0, 0);
    vecs++;
    if (dut_vec !== 23'({8'h01, 4'd0, 1'b0, 8'h01, 1'b0, 1'b0})) begin
      fails++; $display("FAIL reset_values: got %h exp %h", dut_vec,
                        23'({8'h01, 4'd0, 1'b0, 8'h01, 1'b0, 1'b0}));
    end
  endtask

  task automatic test_load();
    logic [7:0] seq [6] = '{8'h09, 8'h10, 8'h13, 8'h05, 8'h00, 8'h0A};
    for (int i = 0; i < 6; i++) begin
      cyc(1, seq[i], 0, 0, 0, 0);
      vecs++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL load_%0d data %h: got %h exp %h", i, seq[i], dut_vec, exp_vec());
      end
    end
    cyc(1, 8'h12, 0, 0, 0, 0);
    vecs++;
    if (mes_bcd !== 8'h12 || mes_idx !== 4'd11 || bcd_err !== 1'b0) begin
      fails++; $display("FAIL load_12: got %h/%0d/%b exp 12/11/0", mes_bcd, mes_idx, bcd_err);
    end
  endtask

  task automatic test_edit_wrap();
    // up, down, down(12->11), load ignored, up+down together, then exit to write
    bit sup [6] = '{0, 1, 0, 0, 1, 0};
    bit sdn [6] = '{0, 0, 1, 0, 1, 1};
    bit sld [6] = '{0, 0, 0, 1, 0, 0};
    cyc(1, 8'h12, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(sld[i], 8'h07, 1, sup[i], sdn[i], 0);
      vecs++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL edit_wrap_%0d: got %h exp %h", i, dut_vec, exp_vec());
      end
    end
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 1);
    cyc(1, 8'h10, 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 1, 0);
    vecs++;
    if (mes_bcd !== 8'h09 || mes_idx !== 4'd8) begin
      fails++; $display("FAIL edit_10_down: got %h/%0d exp 09/8", mes_bcd, mes_idx);
    end
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 1);
  endtask

  task automatic test_write_handshake();
    cyc(1, 8'h03, 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0);
    cyc(0, 8'h00, 1, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);
    vecs++;
    if (wr_req !== 1'b1 || wr_data !== 8'h04) begin
      fails++; $display("FAIL write_entry: got req %b data %h exp 1 04", wr_req, wr_data);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(i == 2, 8'h08, i == 3, i == 1, 0, 0);
      vecs++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL write_hold_%0d: got %h exp %h", i, dut_vec, exp_vec());
      end
    end
    cyc(0, 8'h00, 0, 0, 0, 1);
    vecs++;
    if (dut_vec !== exp_vec()) begin
      fails++; $display("FAIL write_ack: got %h exp %h", dut_vec, exp_vec());
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, i < 2, 0, 0, 0);
      vecs++;
      if (wr_req !== 1'b0) begin
        fails++; $display("FAIL clean_edit_%0d: got req %b exp 0", i, wr_req);
      end
    end
  endtask

  task automatic test_load_edit_same();
    cyc(1, 8'h07, 1, 0, 0, 0);
    cyc(0, 8'h00, 1, 1, 0, 0);
    vecs++;
    if (mes_bcd !== 8'h07 || dut_vec !== exp_vec()) begin
      fails++; $display("FAIL load_edit_same: got %h exp %h", dut_vec, exp_vec());
    end
    cyc(0, 8'h00, 1, 1, 0, 0);
    vecs++;
    if (mes_bcd !== 8'h08 || dut_vec !== exp_vec()) begin
      fails++; $display("FAIL edit_after_load: got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid_write();
    cyc(0, 8'h00, 0, 0, 0, 0);
    vecs++;
    if (wr_req !== 1'b1) begin
      fails++; $display("FAIL pre_reset_write: got req %b exp 1", wr_req);
    end
    #1 rst_n = 0;
    #2;
    model_reset();
    vecs++;
    if (dut_vec !== exp_vec()) begin
      fails++; $display("FAIL async_reset: got %h exp %h", dut_vec, exp_vec());
    end
    #1 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 8'h00, 0, 0, 0, 0);
      vecs++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL post_reset_%0d: got %h exp %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_timeout();
    cyc(1, 8'h11, 0, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0, 0);
    cyc(0, 8'h00, 1, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 8'h00, 0, 0, 0, 0);
      vecs++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL timeout_%0d: got %h exp %h", i, dut_vec, exp_vec());
      end
    end
    // ack on the expiring cycle: ack wins, no pulse
    cyc(0, 8'h00, 1, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 1, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < TCYC + 1; i++) begin
      cyc(0, 8'h00, 0, 0, 0, i == TCYC - 1);
      vecs++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL ack_at_expiry_%0d: got %h exp %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit en = 0;
    logic [7:0] d;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0) en = ~en;
      if ($urandom_range(1) == 0) d = to_bcd(int'($urandom_range(12, 1)));
      else d = 8'($urandom_range(8'h1F));
      cyc($urandom_range(4) == 0, d, en, $urandom_range(2) == 0,
          $urandom_range(2) == 0, $urandom_range(2) == 0);
      vecs++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL random_%0d: got %h exp %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_edit_wrap();
    test_write_handshake();
    test_load_edit_same();
    cyc(0, 8'h00, 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 1);
    cyc(0, 8'h00, 1, 0, 0, 0);
    cyc(0, 8'h00, 1, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0);
    test_reset_mid_write();
    if (TO_EN) test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/mes_bcd_ctrl.md
# mes_bcd_ctrl

Sequential month register for the RTC date path. Holds the current month as RTC-format BCD (8'h01–8'h12) together with its 4-bit binary index (0–11, index = month − 1).

- The value is loaded from RTC read data and can be edited by user up/down pulses.
- After an edit, the block issues a write request with handshake back toward the RTC write path.
- It is the writer/encoder side of the month index → BCD decode used by the display path.

## Interface

- TIMEOUT_CYC, 255, cycles to wait for wr_ack before abandoning a write. Used only when MES_WR_TIMEOUT_EN is defined; range 1–255.

- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- load  input  1  one-cycle pulse: capture rtc_data_in as the month
- rtc_data_in  input  8  BCD month read from RTC
- edit_en  input  1  level: user edit mode requested
- btn_up  input  1  one-cycle pulse: month + 1 (edit mode only)
- btn_down  input  1  one-cycle pulse: month − 1 (edit mode only)
- wr_ack  input  1  write path accepted wr_data
- mes_bcd  output  8  current month, BCD
- mes_idx  output  4  current month index, 0–11
- wr_req  output  1  write request, level, held until ack
- wr_data  output  8  BCD month to write; equals mes_bcd while wr_req = 1
- bcd_err  output  1  sticky flag: last load carried an invalid BCD month
- wr_timeout  output  1  one-cycle pulse: write abandoned (macro builds only; tied 0 otherwise)

## Operation

- Reset values (asynchronous, on rst_n = 0):
  - mes_bcd = 8'h01, mes_idx = 0
  - wr_req = 0, wr_data = 8'h01
  - bcd_err = 0, wr_timeout = 0
  - state = IDLE, dirty = 0
- Invariant: mes_idx always corresponds to mes_bcd. Valid set: 01–09, 10, 11, 12 (BCD).
- IDLE:
  - load = 1 and rtc_data_in valid → update mes_bcd/mes_idx, clear bcd_err.
  - load = 1 and rtc_data_in invalid (e.g. 8'h00, 8'h0A, 8'h13) → value unchanged, bcd_err = 1.
  - edit_en = 1 → EDIT, dirty cleared.
  - load and edit_en both high in the same cycle → the load is performed and the state stays IDLE; EDIT is entered on the next cycle if edit_en is still high.
- EDIT:
  - btn_up: 12 → 01 wraps, otherwise +1 in BCD (09 → 10). Sets dirty.
  - btn_down: 01 → 12 wraps, otherwise −1 (10 → 09). Sets dirty.
  - btn_up and btn_down in the same cycle → no change.
  - load is ignored.
  - edit_en = 0 → WRITE if dirty, else IDLE.
- WRITE:
  - wr_req = 1; wr_data is frozen at the month value on entry.
  - Button pulses and load are ignored.
  - wr_ack = 1 → wr_req = 0 and return to IDLE.
  - wr_ack while not in WRITE is ignored.
- States: IDLE, EDIT, WRITE.

## Timing

- All outputs are registered; no combinational input → output paths.
- load sampled at edge N → mes_bcd, mes_idx and bcd_err valid after edge N (1-cycle latency).
- btn pulse at edge N → new value after edge N.
- edit_en low sampled at edge N (dirty) → wr_req = 1 after edge N.
- wr_ack high sampled at edge N → wr_req = 0 after edge N.
- Minimum request length is 1 cycle: ack may be high on the first cycle of wr_req.
- Reset mid-write drops wr_req immediately (asynchronous); no write is retried.

## Configuration

- MES_WR_TIMEOUT_EN defined:
  - An 8-bit counter starts at WRITE entry.
  - If TIMEOUT_CYC cycles elapse without wr_ack → wr_req = 0, wr_timeout pulses for 1 cycle, state = IDLE. mes_bcd keeps the edited value.
  - If wr_ack arrives in the same cycle the count expires, ack wins and there is no timeout pulse.
- MES_WR_TIMEOUT_EN undefined: wr_req is held indefinitely until wr_ack; wr_timeout is constant 0; no counter logic.

## Test plan

- Reset → mes_bcd = 8'h01, mes_idx = 0, wr_req = 0, bcd_err = 0.
- load with 8'h09, then 8'h10, then 8'h13 → 09/idx 8, then 10/idx 9, then value stays 10 with bcd_err = 1; a following load of 8'h05 → 05/idx 4 and bcd_err = 0.
- EDIT at 12 → btn_up gives 01; btn_down gives 12; from 10, btn_down gives 09; up + down together → unchanged.
- Edit 03 → 04, drop edit_en → wr_req = 1 and wr_data = 8'h04 the next cycle; ack after 5 cycles → wr_req low next cycle, state IDLE. Enter/exit EDIT without buttons → no wr_req.
- load + edit_en in the same cycle → value loaded and EDIT entered one cycle later. rst_n pulsed low during WRITE → wr_req drops asynchronously and all outputs return to reset values.
- MES_WR_TIMEOUT_EN, TIMEOUT_CYC = 4, no ack → wr_req high 4 cycles, then wr_timeout 1-cycle pulse and IDLE.
